// File: rtl/common_pkg.sv
// -----------------------------------------------------------------------------
// common_pkg
// Shared tile/fabric types and core-wide constants.
//   t_opcode      : fabric transaction opcode (RD, WR, RD_RSP, WR_RSP)
//   t_tile_trans  : fabric transaction (opcode, address, data)
//   F2C_RSP_BUF_DEPTH / F2C_RD_LAT : fabric-to-core response buffer sizing
//   countOnes()   : population count helper for small status vectors
// -----------------------------------------------------------------------------
package common_pkg;

   typedef enum logic [1:0] {
      RD     = 2'd0,
      WR     = 2'd1,
      RD_RSP = 2'd2,
      WR_RSP = 2'd3
   } t_opcode;

   typedef struct packed {
      t_opcode     opcode;
      logic [31:0] address;
      logic [31:0] data;
   } t_tile_trans;

   localparam int F2C_RSP_BUF_DEPTH = 4;
   localparam int F2C_RD_LAT        = 2;

   // Number of set bits in a vector (callers zero-extend to 32 bits).
   function automatic int countOnes(input logic [31:0] vec);
      int ones;
      ones = 0;
      for (int i = 0; i < 32; i++) begin
         ones = ones + int'(vec[i]);
      end
      return ones;
   endfunction

endpackage

// File: rtl/big_core_rsp_fifo_mem.sv
// -----------------------------------------------------------------------------
// big_core_rsp_fifo_mem
// DEPTH-entry storage array for the fabric-to-core response buffer. Written at
// WrPtr when WrEn is high, read asynchronously at RdPtr. The array is not reset;
// the parent never presents an entry that was not written since reset.
//   Clk    in  : core clock
//   WrEn   in  : write strobe
//   WrPtr  in  : write slot
//   WrData in  : entry to store
//   RdPtr  in  : read slot
//   RdData out : entry at RdPtr
// -----------------------------------------------------------------------------
module big_core_rsp_fifo_mem
   import common_pkg::*;
#(
   parameter int DEPTH = F2C_RSP_BUF_DEPTH,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              WrEn,
   input  logic [PTR_W-1:0]  WrPtr,
   input  t_tile_trans       WrData,
   input  logic [PTR_W-1:0]  RdPtr,
   output t_tile_trans       RdData
);

   t_tile_trans mem_r [DEPTH];

   // Data array write port.
   always_ff @(posedge Clk) begin
      if (WrEn) begin
         mem_r[WrPtr] <= WrData;
      end
   end

   assign RdData = mem_r[RdPtr];

endmodule

// File: rtl/big_core_f2c_rsp_buf.sv
// -----------------------------------------------------------------------------
// big_core_f2c_rsp_buf
// Buffers read responses from the core memory wrapper (no backpressure at
// Q505H) and hands them to the tile with a valid/ready handshake. RDs snooped
// at Q503H are tracked for RD_LAT cycles so RdReqReady only grants a new RD when
// buffer occupancy plus responses still in the memory pipeline leaves room.
//   Clk, RstN              : clock, asynchronous active-low reset
//   InFabricValidQ503H/Q503H : snooped fabric request (only opcode used)
//   RdReqReady             : one more RD may be issued this cycle
//   RspValidQ505H/RspQ505H : read response from memory wrapper
//   OutRspValid/OutRsp/OutRspReady : buffered response handshake toward tile
//   RspCount               : occupied buffer entries
//   ProtErr                : sticky overflow / credit-violation flag
// Build option: define BIG_CORE_F2C_RSP_BYPASS_EN to forward a response
// straight to OutRsp in the same cycle when the buffer is empty.
// -----------------------------------------------------------------------------
module big_core_f2c_rsp_buf
   import common_pkg::*;
#(
   parameter int DEPTH  = F2C_RSP_BUF_DEPTH,
   parameter int RD_LAT = F2C_RD_LAT,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              Clk,
   input  logic              RstN,
   input  logic              InFabricValidQ503H,
   input  t_tile_trans       InFabricQ503H,
   output logic              RdReqReady,
   input  logic              RspValidQ505H,
   input  t_tile_trans       RspQ505H,
   output logic              OutRspValid,
   output t_tile_trans       OutRsp,
   input  logic              OutRspReady,
   output logic [CNT_W-1:0]  RspCount,
   output logic              ProtErr
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int SUM_W = $clog2(DEPTH + RD_LAT + 1);

   logic [PTR_W-1:0]  wrPtr_r;
   logic [PTR_W-1:0]  rdPtr_r;
   logic [CNT_W-1:0]  count_r;
   logic [RD_LAT-1:0] inFlight_r;
   logic              protErr_r;

   logic              rdSnoop_s;
   logic [RD_LAT-1:0] inFlightNext_s;
   logic [SUM_W-1:0]  numInFlight_s;
   logic [SUM_W-1:0]  occupancy_s;
   logic              rdReqReady_s;
   logic              fifoEmpty_s;
   logic              fifoFull_s;
   logic              fifoPop_s;
   logic              bypassTake_s;
   logic              fifoWrite_s;
   logic              drop_s;
   logic              protViol_s;
   t_tile_trans       headRsp_s;
   logic              unusedReqFields_s;

   // Only the opcode of the snooped request matters here.
   assign unusedReqFields_s = ^{InFabricQ503H.address, InFabricQ503H.data};

   assign rdSnoop_s     = InFabricValidQ503H && (InFabricQ503H.opcode == RD);
   assign numInFlight_s = SUM_W'(countOnes(32'(inFlight_r)));
   assign occupancy_s   = SUM_W'(count_r) + numInFlight_s;
   // Credit uses registered state only, so a same-cycle pop is not credited.
   assign rdReqReady_s  = (occupancy_s < SUM_W'(DEPTH));

   assign fifoEmpty_s = (count_r == CNT_W'(0));
   assign fifoFull_s  = (count_r == CNT_W'(DEPTH));
   assign fifoPop_s   = !fifoEmpty_s && OutRspReady;

`ifdef BIG_CORE_F2C_RSP_BYPASS_EN
   // A response consumed straight from the input never enters the array.
   assign bypassTake_s = fifoEmpty_s && RspValidQ505H && OutRspReady;
`else
   assign bypassTake_s = 1'b0;
`endif

   // A full buffer still accepts a push when the head leaves the same cycle.
   assign fifoWrite_s = RspValidQ505H && !bypassTake_s && (!fifoFull_s || fifoPop_s);
   assign drop_s      = RspValidQ505H && fifoFull_s && !fifoPop_s;
   assign protViol_s  = drop_s || (rdSnoop_s && !rdReqReady_s);

   // Age the in-flight RD markers; the oldest falls off as its response lands.
   always_comb begin
      inFlightNext_s    = inFlight_r << 1'b1;
      inFlightNext_s[0] = rdSnoop_s;
   end

   big_core_rsp_fifo_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .Clk    (Clk),
      .WrEn   (fifoWrite_s),
      .WrPtr  (wrPtr_r),
      .WrData (RspQ505H),
      .RdPtr  (rdPtr_r),
      .RdData (headRsp_s)
   );

   // Pointer, occupancy, in-flight and sticky error state.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         wrPtr_r    <= PTR_W'(0);
         rdPtr_r    <= PTR_W'(0);
         count_r    <= CNT_W'(0);
         inFlight_r <= RD_LAT'(0);
         protErr_r  <= 1'b0;
      end else begin
         if (fifoWrite_s) begin
            wrPtr_r <= wrPtr_r + PTR_W'(1);
         end
         if (fifoPop_s) begin
            rdPtr_r <= rdPtr_r + PTR_W'(1);
         end
         case ({fifoWrite_s, fifoPop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         inFlight_r <= inFlightNext_s;
         if (protViol_s) begin
            protErr_r <= 1'b1;
         end
      end
   end

   // Present the head entry; OutRsp is forced to zero while nothing is valid.
   always_comb begin
      OutRspValid = 1'b0;
      OutRsp      = '0;
      if (!fifoEmpty_s) begin
         OutRspValid = 1'b1;
         OutRsp      = headRsp_s;
      end
`ifdef BIG_CORE_F2C_RSP_BYPASS_EN
      else if (RspValidQ505H) begin
         OutRspValid = 1'b1;
         OutRsp      = RspQ505H;
      end
`endif
      else begin
         OutRspValid = 1'b0;
         OutRsp      = '0;
      end
   end

   assign RdReqReady = rdReqReady_s;
   assign RspCount   = count_r;
   assign ProtErr    = protErr_r;

endmodule

// File: tb/tb_big_core_f2c_rsp_buf.sv
// -----------------------------------------------------------------------------
// tb_big_core_f2c_rsp_buf
// Self-checking bench for big_core_f2c_rsp_buf. A queue-based reference keeps
// the buffered responses and the RDs issued in the last RD_LAT cycles; each
// scenario task compares the DUT against it and against fixed expectations.
// Honours BIG_CORE_F2C_RSP_BYPASS_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_big_core_f2c_rsp_buf;
   import common_pkg::*;

   localparam int DEPTH  = F2C_RSP_BUF_DEPTH;
   localparam int RD_LAT = F2C_RD_LAT;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              Clk = 1'b0;
   logic              RstN;
   logic              InFabricValidQ503H;
   t_tile_trans       InFabricQ503H;
   logic              RdReqReady;
   logic              RspValidQ505H;
   t_tile_trans       RspQ505H;
   logic              OutRspValid;
   t_tile_trans       OutRsp;
   logic              OutRspReady;
   logic [CNT_W-1:0]  RspCount;
   logic              ProtErr;

   always #5 Clk = ~Clk;

   big_core_f2c_rsp_buf dut (
      .Clk                (Clk),
      .RstN               (RstN),
      .InFabricValidQ503H (InFabricValidQ503H),
      .InFabricQ503H      (InFabricQ503H),
      .RdReqReady         (RdReqReady),
      .RspValidQ505H      (RspValidQ505H),
      .RspQ505H           (RspQ505H),
      .OutRspValid        (OutRspValid),
      .OutRsp             (OutRsp),
      .OutRspReady        (OutRspReady),
      .RspCount           (RspCount),
      .ProtErr            (ProtErr)
   );

   int total = 0;
   int bad   = 0;

   // Reference state
   t_tile_trans mq[$];
   int          hist[RD_LAT];
   logic        errM;

   // Expected outputs for the current cycle
   logic        expValid;
   t_tile_trans expRsp;
   int          expCount;
   logic        expReady;
   logic        expErr;

   function automatic int inflight();
      int n = 0;
      for (int i = 0; i < RD_LAT; i++) n += hist[i];
      return n;
   endfunction

   task automatic model_reset();
      mq.delete();
      for (int i = 0; i < RD_LAT; i++) hist[i] = 0;
      errM = 1'b0;
   endtask

   // Drive one cycle of inputs (at the falling edge) and derive expectations.
   task automatic apply(input logic rd, input logic wr, input logic push,
                        input logic [31:0] d, input logic rdy);
      InFabricValidQ503H = rd | wr;
      InFabricQ503H      = '{opcode: (wr ? WR : RD), address: $urandom(), data: $urandom()};
      RspValidQ505H      = push;
      RspQ505H           = '{opcode: RD_RSP, address: $urandom(), data: d};
      OutRspReady        = rdy;
      #1;
      expCount = mq.size();
      expReady = (mq.size() + inflight()) < DEPTH;
      expErr   = errM;
      if (mq.size() != 0) begin
         expValid = 1'b1;
         expRsp   = mq[0];
      end
`ifdef BIG_CORE_F2C_RSP_BYPASS_EN
      else if (push) begin
         expValid = 1'b1;
         expRsp   = RspQ505H;
      end
`endif
      else begin
         expValid = 1'b0;
         expRsp   = '0;
      end
   endtask

   // Advance one clock and move the reference by the rules of the buffer.
   task automatic tick();
      logic rdS, credit, byp;
      @(posedge Clk);
      rdS    = InFabricValidQ503H && (InFabricQ503H.opcode == RD);
      credit = (mq.size() + inflight()) < DEPTH;
      byp    = 1'b0;
`ifdef BIG_CORE_F2C_RSP_BYPASS_EN
      byp    = (mq.size() == 0) && RspValidQ505H && OutRspReady;
`endif
      if (mq.size() != 0 && OutRspReady) void'(mq.pop_front());
      if (RspValidQ505H && !byp) begin
         if (mq.size() < DEPTH) mq.push_back(RspQ505H);
         else errM = 1'b1;
      end
      if (rdS && !credit) errM = 1'b1;
      for (int i = RD_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(rdS);
      @(negedge Clk);
   endtask

   task automatic do_reset();
      RstN = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic release_reset();
      @(posedge Clk);
      @(negedge Clk);
      RstN = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      total++; if (OutRspValid !== 1'b0) begin bad++; $display("FAIL reset.valid got=%0b exp=0", OutRspValid); end
      total++; if (OutRsp !== expRsp) begin bad++; $display("FAIL reset.rsp got=%h exp=%h", OutRsp, expRsp); end
      total++; if (RspCount !== CNT_W'(0)) begin bad++; $display("FAIL reset.count got=%0d exp=0", RspCount); end
      total++; if (RdReqReady !== 1'b1) begin bad++; $display("FAIL reset.ready got=%0b exp=1", RdReqReady); end
      total++; if (ProtErr !== 1'b0) begin bad++; $display("FAIL reset.err got=%0b exp=0", ProtErr); end
      release_reset();
   endtask

   task automatic test_single_rd();
      int showCyc;
`ifdef BIG_CORE_F2C_RSP_BYPASS_EN
      showCyc = 2;
`else
      showCyc = 3;
`endif
      for (int c = 0; c < 5; c++) begin
         apply(c == 0, 1'b0, c == 2, 32'hDEAD_BEEF, 1'b1);
         total++; if (OutRspValid !== expValid) begin bad++; $display("FAIL single.valid c=%0d got=%0b exp=%0b", c, OutRspValid, expValid); end
         total++; if (OutRsp !== expRsp) begin bad++; $display("FAIL single.rsp c=%0d got=%h exp=%h", c, OutRsp, expRsp); end
         total++; if (int'(RspCount) !== expCount) begin bad++; $display("FAIL single.count c=%0d got=%0d exp=%0d", c, RspCount, expCount); end
         total++; if (RdReqReady !== expReady) begin bad++; $display("FAIL single.ready c=%0d got=%0b exp=%0b", c, RdReqReady, expReady); end
         if (c == showCyc) begin
            total++; if (OutRspValid !== 1'b1 || OutRsp.data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single.data c=%0d got=%0b/%h exp=1/deadbeef", c, OutRspValid, OutRsp.data); end
         end
         tick();
      end
      total++; if (RspCount !== CNT_W'(0) || ProtErr !== 1'b0) begin bad++; $display("FAIL single.end got=%0d/%0b exp=0/0", RspCount, ProtErr); end
   endtask

   task automatic test_fill_drain();
      for (int c = 0; c < 12; c++) begin
         apply(c < 4, 1'b0, (c >= 2) && (c < 6), 32'hA000 + 32'(c), c >= 6);
         total++; if (OutRspValid !== expValid) begin bad++; $display("FAIL fill.valid c=%0d got=%0b exp=%0b", c, OutRspValid, expValid); end
         total++; if (OutRsp !== expRsp) begin bad++; $display("FAIL fill.rsp c=%0d got=%h exp=%h", c, OutRsp, expRsp); end
         total++; if (int'(RspCount) !== expCount) begin bad++; $display("FAIL fill.count c=%0d got=%0d exp=%0d", c, RspCount, expCount); end
         total++; if (RdReqReady !== expReady) begin bad++; $display("FAIL fill.ready c=%0d got=%0b exp=%0b", c, RdReqReady, expReady); end
         if (c == 4) begin
            total++; if (RdReqReady !== 1'b0) begin bad++; $display("FAIL fill.credit_drop got=%0b exp=0", RdReqReady); end
         end
         if (c == 6) begin
            total++; if (RspCount !== CNT_W'(4)) begin bad++; $display("FAIL fill.full got=%0d exp=4", RspCount); end
         end
         if (c >= 6 && c < 10) begin
            total++; if (OutRsp.data !== 32'hA000 + 32'(c - 4)) begin bad++; $display("FAIL fill.order c=%0d got=%h exp=%h", c, OutRsp.data, 32'hA000 + 32'(c - 4)); end
         end
         tick();
      end
      total++; if (ProtErr !== 1'b0) begin bad++; $display("FAIL fill.err got=%0b exp=0", ProtErr); end
   endtask

   task automatic test_full_pushpop();
      for (int c = 0; c < 10; c++) begin
         apply(1'b0, 1'b0, c <= 4, (c == 4) ? 32'h1234 : 32'hB000 + 32'(c), c >= 4);
         total++; if (OutRsp !== expRsp) begin bad++; $display("FAIL fullpp.rsp c=%0d got=%h exp=%h", c, OutRsp, expRsp); end
         total++; if (int'(RspCount) !== expCount) begin bad++; $display("FAIL fullpp.count c=%0d got=%0d exp=%0d", c, RspCount, expCount); end
         if (c == 5) begin
            total++; if (RspCount !== CNT_W'(4)) begin bad++; $display("FAIL fullpp.keep got=%0d exp=4", RspCount); end
         end
         if (c == 8) begin
            total++; if (OutRsp.data !== 32'h1234) begin bad++; $display("FAIL fullpp.fourth got=%h exp=1234", OutRsp.data); end
         end
         tick();
      end
      total++; if (ProtErr !== 1'b0) begin bad++; $display("FAIL fullpp.err got=%0b exp=0", ProtErr); end
   endtask

   task automatic test_overflow();
      for (int c = 0; c < 11; c++) begin
         apply(1'b0, 1'b0, c <= 4, (c == 4) ? 32'hDEAD : 32'hC000 + 32'(c), c >= 6);
         total++; if (OutRsp !== expRsp) begin bad++; $display("FAIL ovf.rsp c=%0d got=%h exp=%h", c, OutRsp, expRsp); end
         total++; if (int'(RspCount) !== expCount) begin bad++; $display("FAIL ovf.count c=%0d got=%0d exp=%0d", c, RspCount, expCount); end
         total++; if (ProtErr !== expErr) begin bad++; $display("FAIL ovf.err c=%0d got=%0b exp=%0b", c, ProtErr, expErr); end
         if (c == 5) begin
            total++; if (ProtErr !== 1'b1 || RspCount !== CNT_W'(4)) begin bad++; $display("FAIL ovf.drop got=%0b/%0d exp=1/4", ProtErr, RspCount); end
         end
         tick();
      end
      total++; if (ProtErr !== 1'b1) begin bad++; $display("FAIL ovf.sticky got=%0b exp=1", ProtErr); end
      do_reset();
      total++; if (ProtErr !== 1'b0) begin bad++; $display("FAIL ovf.clear got=%0b exp=0", ProtErr); end
      release_reset();
   endtask

   task automatic test_snoop_err_wr();
      for (int c = 0; c < 10; c++) begin
         apply((c == 6) || (c == 8), (c >= 3 && c <= 5) || (c == 7), c <= 2, 32'hE000 + 32'(c), 1'b0);
         total++; if (RdReqReady !== expReady) begin bad++; $display("FAIL snoop.ready c=%0d got=%0b exp=%0b", c, RdReqReady, expReady); end
         total++; if (ProtErr !== expErr) begin bad++; $display("FAIL snoop.err c=%0d got=%0b exp=%0b", c, ProtErr, expErr); end
         if (c >= 3 && c <= 6) begin
            total++; if (RdReqReady !== 1'b1 || ProtErr !== 1'b0) begin bad++; $display("FAIL snoop.wr c=%0d got=%0b/%0b exp=1/0", c, RdReqReady, ProtErr); end
         end
         if (c == 7 || c == 8) begin
            total++; if (RdReqReady !== 1'b0) begin bad++; $display("FAIL snoop.nocredit c=%0d got=%0b exp=0", c, RdReqReady); end
         end
         if (c == 9) begin
            total++; if (ProtErr !== 1'b1) begin bad++; $display("FAIL snoop.viol got=%0b exp=1", ProtErr); end
         end
         tick();
      end
      do_reset();
      release_reset();
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 5; c++) begin
         apply(c >= 3, 1'b0, c <= 2, 32'hF000 + 32'(c), 1'b0);
         tick();
      end
      total++; if (RspCount !== CNT_W'(3)) begin bad++; $display("FAIL rstmid.pre got=%0d exp=3", RspCount); end
      do_reset();
      total++; if (OutRspValid !== 1'b0) begin bad++; $display("FAIL rstmid.valid got=%0b exp=0", OutRspValid); end
      total++; if (RspCount !== CNT_W'(0)) begin bad++; $display("FAIL rstmid.count got=%0d exp=0", RspCount); end
      total++; if (RdReqReady !== 1'b1) begin bad++; $display("FAIL rstmid.ready got=%0b exp=1", RdReqReady); end
      release_reset();
      for (int c = 0; c < 5; c++) begin
         apply(1'b0, 1'b0, c <= 1, 32'h5A00 + 32'(c), c >= 2);
         total++; if (OutRspValid !== expValid) begin bad++; $display("FAIL rstmid.lvalid c=%0d got=%0b exp=%0b", c, OutRspValid, expValid); end
         total++; if (OutRsp !== expRsp) begin bad++; $display("FAIL rstmid.lrsp c=%0d got=%h exp=%h", c, OutRsp, expRsp); end
         total++; if (int'(RspCount) !== expCount) begin bad++; $display("FAIL rstmid.lcount c=%0d got=%0d exp=%0d", c, RspCount, expCount); end
         total++; if (ProtErr !== expErr) begin bad++; $display("FAIL rstmid.lerr c=%0d got=%0b exp=%0b", c, ProtErr, expErr); end
         tick();
      end
   endtask

   task automatic test_random();
      logic rd, wr, push;
      for (int c = 0; c < 400; c++) begin
         rd   = ((mq.size() + inflight()) < DEPTH) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 31) == 0);
         wr   = !rd && ($urandom_range(0, 2) == 0);
         push = (hist[RD_LAT-1] != 0) || ($urandom_range(0, 15) == 0);
         apply(rd, wr, push, $urandom(), $urandom_range(0, 2) != 0);
         total++; if (OutRspValid !== expValid) begin bad++; $display("FAIL rand.valid c=%0d got=%0b exp=%0b", c, OutRspValid, expValid); end
         total++; if (OutRsp !== expRsp) begin bad++; $display("FAIL rand.rsp c=%0d got=%h exp=%h", c, OutRsp, expRsp); end
         total++; if (int'(RspCount) !== expCount) begin bad++; $display("FAIL rand.count c=%0d got=%0d exp=%0d", c, RspCount, expCount); end
         total++; if (RdReqReady !== expReady) begin bad++; $display("FAIL rand.ready c=%0d got=%0b exp=%0b", c, RdReqReady, expReady); end
         total++; if (ProtErr !== expErr) begin bad++; $display("FAIL rand.err c=%0d got=%0b exp=%0b", c, ProtErr, expErr); end
         tick();
      end
   endtask

   initial begin
      RstN               = 1'b0;
      InFabricValidQ503H = 1'b0;
      InFabricQ503H      = '0;
      RspValidQ505H      = 1'b0;
      RspQ505H           = '0;
      OutRspReady        = 1'b0;
      model_reset();
      @(negedge Clk);
      test_reset();
      test_single_rd();
      test_fill_drain();
      test_full_pushpop();
      test_overflow();
      test_snoop_err_wr();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/big_core_f2c_rsp_buf.md
Name: big_core_f2c_rsp_buf

Overview:
Buffers fabric-to-core read responses from the core memory wrapper (Q505H output), which has no backpressure, and presents them to the tile's outgoing fabric port with a valid/ready handshake. It snoops the Q503H fabric request stream to count read responses still in the memory pipeline. From that count it produces a credit signal (RdReqReady) telling the tile whether one more RD may be issued without overflowing the buffer. It sits between the memory wrapper output and the tile output arbiter.

Parameters:
DEPTH, 4, response FIFO entries (power of 2, >= RD_LAT)
RD_LAT, 2, cycles from RD at Q503H to response valid at Q505H

Ports:
Clk  in  1  core clock
RstN  in  1  asynchronous active-low reset
InFabricValidQ503H  in  1  fabric request valid, snooped at memory wrapper input
InFabricQ503H  in  t_tile_trans  fabric request, snooped (only .opcode used)
RdReqReady  out  1  a RD may be issued to the memory wrapper this cycle
RspValidQ505H  in  1  read response valid from memory wrapper
RspQ505H  in  t_tile_trans  read response from memory wrapper
OutRspValid  out  1  buffered response valid toward tile
OutRsp  out  t_tile_trans  buffered response
OutRspReady  in  1  tile accepts OutRsp
RspCount  out  $clog2(DEPTH+1)  occupied FIFO entries
ProtErr  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async on RstN low, released synchronously by design): FIFO empty, pointers 0, InFlight shift register 0, OutRspValid=0, OutRsp='0, RspCount=0, RdReqReady=1, ProtErr=0. Reset mid-operation discards all stored and in-flight responses.
- RdSnoop = InFabricValidQ503H && InFabricQ503H.opcode==RD. WR requests are ignored and never gated.
- InFlight: RD_LAT-bit shift register, shifted in with RdSnoop each cycle. NumInFlight = popcount.
- RdReqReady = (RspCount + NumInFlight) < DEPTH, computed from registered state only. It ignores a same-cycle pop, which makes it conservative.
- Push = RspValidQ505H. Pop = OutRspValid && OutRspReady.
- RspQ505H is stored unmodified; opcode is not checked.
- OutRspValid = (RspCount != 0). OutRsp = head entry, stable while valid and not ready.
- Latency (no bypass): a push into an empty FIFO at cycle N gives OutRspValid=1 at N+1.
- Simultaneous push+pop: count unchanged, including when full. Push+pop when empty is only possible with bypass.
- Push when full without pop: entry dropped, count stays DEPTH, ProtErr set.
- RdSnoop while RdReqReady=0: request still tracked in InFlight, ProtErr set.
- Pointers are log2(DEPTH) bits and wrap naturally. Count saturates at 0 and DEPTH and never wraps.
- ProtErr clears only on reset.

Optional Feature:
BIG_CORE_F2C_RSP_BYPASS_EN
- Defined: when the FIFO is empty and Push=1, OutRspValid=1 and OutRsp=RspQ505H combinationally in the same cycle.
  - If OutRspReady=1 that cycle, the entry is not written and count stays 0.
  - Otherwise it is written and presented next cycle as normal.
- Undefined: registered-only path with 1-cycle latency, as above.

Decomposition:
- Add to common_pkg: F2C_RSP_BUF_DEPTH=4 and F2C_RD_LAT=2.
- t_tile_trans, RD and RD_RSP already exist in common_pkg and are reused.
- One sub-module: big_core_rsp_fifo_mem.
  - DEPTH x t_tile_trans register array.
  - Write-pointer write and read-pointer read.
  - No reset on the data array.
- The credit, InFlight and error logic stays in the top module.

Test Plan:
- Single RD at cycle 0, response 0xDEAD_BEEF pushed at cycle 2, OutRspReady=1 -> OutRspValid=1 with data 0xDEADBEEF at cycle 3 (cycle 2 with bypass). RspCount returns to 0, ProtErr=0.
- OutRspReady=0, four back-to-back RDs (cycles 0-3) -> RdReqReady drops to 0 after the fourth RD, RspCount reaches 4. Releasing ready pops one entry per cycle in order; RdReqReady reasserts once count + in-flight < 4.
- FIFO full, OutRspReady=1, push 0x1234 in the same cycle -> RspCount stays 4, no drop, ProtErr=0, 0x1234 emerges fourth.
- FIFO full, OutRspReady=0, extra push -> entry dropped, RspCount=4, ProtErr=1 and stays 1.
- RD snooped while RdReqReady=0 -> ProtErr=1. WR snooped at any time -> no InFlight change, RdReqReady unchanged.
- RstN low for 1 cycle with 3 entries stored and 2 RDs in flight -> OutRspValid=0, RspCount=0, RdReqReady=1 immediately; late responses after reset are accepted normally.
